pmem_arbiter: RTL

Arbitrates the single physical-memory port between the instruction cache and the data cache. Each cache's controller raises its own `pmem_read`/`pmem_write` toward the arbiter as if it owned memory. The arbiter grants one requester at a time, registers that requester's address and write data onto the memory port, and routes `pmem_resp` back to the granted side only. It sits between the two `cache_control`/cache-datapath pairs and physical memory.

---
 rtl/pmem_arbiter_pkg.sv | 22 ++
 rtl/pmem_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared types for the physical-memory arbiter: FSM states, requester sides
// and the default memory line type.
package pmem_arbiter_pkg;

    localparam int PMEM_ADDR_W = 16;
    localparam int PMEM_LINE_W = 128;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } arb_side_t;

    typedef logic [PMEM_LINE_W-1:0] pmem_line_t;

endpackage

// File: rtl/pmem_arbiter.sv
// Shares one physical-memory port between the I-cache and D-cache controllers,
// latching the winner's request and routing the completion back to it alone.
module pmem_arbiter
    import pmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128,
    parameter int FAIR   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_address,
    input  logic [LINE_W-1:0] i_wdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] IDLE    = ARB_IDLE;
    localparam logic [1:0] SERVE_I = ARB_SERVE_I;
    localparam logic [1:0] SERVE_D = ARB_SERVE_D;
    localparam logic [1:0] RELEASE = ARB_RELEASE;

    logic [1:0]        state;
    arb_side_t         last_grant;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              write_q;

    logic              i_req;
    logic              d_req;
    logic              pick_d;
    logic [ADDR_W-1:0] win_addr;
    logic [LINE_W-1:0] win_wdata;
    logic              win_write;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    // Round-robin favours whichever side did not win last; fixed mode favours D.
    always_comb begin
        pick_d = 1'b0;
        if (d_req && !i_req) begin
            pick_d = 1'b1;
        end else if (d_req && i_req) begin
            if (FAIR == 0) begin
                pick_d = 1'b1;
            end else begin
                pick_d = (last_grant == SIDE_I);
            end
        end
        win_addr  = pick_d ? d_address : i_address;
        win_wdata = pick_d ? d_wdata   : i_wdata;
        // A simultaneous read and write is served as a write.
        win_write = pick_d ? d_write   : i_write;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= SIDE_I;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state      <= pick_d ? SERVE_D : SERVE_I;
                        last_grant <= pick_d ? SIDE_D : SIDE_I;
                        addr_q     <= win_addr;
                        wdata_q    <= win_wdata;
                        write_q    <= win_write;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // RELEASE keeps everything quiet for one cycle so the cache can drop its request.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        case (state)
            SERVE_I: begin
                pmem_read  = ~write_q;
                pmem_write = write_q;
                i_resp     = pmem_resp;
            end
            SERVE_D: begin
                pmem_read  = ~write_q;
                pmem_write = write_q;
                d_resp     = pmem_resp;
            end
            default: ;
        endcase
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;
    assign rdata        = pmem_rdata;

endmodule
